// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier with start/busy/done handshake, LENGTH_v cycles per product.
// Optional SIGNED_MUL_EN adds an is_signed input for two's-complement operands.
module seq_multiplier #(
  parameter int LENGTH_v = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
`ifdef SIGNED_MUL_EN
  input  logic                  is_signed,
`endif
  input  logic [LENGTH_v-1:0]   A,
  input  logic [LENGTH_v-1:0]   B,
  output logic                  busy,
  output logic                  done,
  output logic [2*LENGTH_v-1:0] P
);
  localparam int CW = $clog2(LENGTH_v + 1);
  localparam logic [CW-1:0] LEN_C = CW'(LENGTH_v);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q;
  logic [LENGTH_v-1:0]   mcand_q;
  logic [2*LENGTH_v-1:0] mplier_q, acc_q, acc_d, prod_c, p_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q, done_q, neg_q, sgn;
  logic [LENGTH_v-1:0]   a_mag, b_mag;
`ifdef SIGNED_MUL_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif
  // Signed mode multiplies magnitudes; the most negative value's magnitude still fits unsigned.
  always_comb begin
    a_mag  = (sgn && A[LENGTH_v-1]) ? -A : A;
    b_mag  = (sgn && B[LENGTH_v-1]) ? -B : B;
    acc_d  = acc_q + (mcand_q[0] ? mplier_q : '0);
    prod_c = neg_q ? -acc_d : acc_d;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          mcand_q  <= a_mag;
          mplier_q <= {{LENGTH_v{1'b0}}, b_mag};
          acc_q    <= '0;
          cnt_q    <= LEN_C;
          neg_q    <= sgn && (A[LENGTH_v-1] ^ B[LENGTH_v-1]);
          busy_q   <= 1'b1;
          state_q  <= RUN;
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q >> 1;
        mplier_q <= mplier_q << 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == 1) begin
          p_q     <= prod_c;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
endmodule
